lsu_bus_adapter: RTL and testbench

Parametrised load/store unit sitting between the RV32I execute stage and the data-memory bus. It accepts one `load_store_type_e` request at a time and generates byte strobes and aligned bus beats. It optionally splits misaligned accesses into two bus beats, then sign- or zero-extends load data and returns a single response pulse. Generalises the width-fixed load/store decode to any `XLEN` and adds misaligned-access handling with error reporting.

---
 rtl/lsu_bus_adapter.sv | 163 ++++++++++++++++
 tb/tb_lsu_bus_adapter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_adapter.sv
// Load/store adapter between the execute stage and a data-memory bus.
// Handles byte strobes, lane shifting, optional misaligned splitting and load extension.
module lsu_bus_adapter #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit MISALIGNED_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [3:0] {
        L_W = 4'd0, L_H = 4'd1, L_HU = 4'd2, L_B = 4'd3, L_BU = 4'd4,
        S_W = 4'd5, S_H = 4'd6, S_B = 4'd7, LS_N_A = 4'd8
    } load_store_type_e;

    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_e;

    state_e state_q, state_d;

    // Request decode, only meaningful while IDLE
    logic [2:0]       dec_size;
    logic             dec_store, dec_signed, dec_cross, dec_err;
    logic [OFF_W-1:0] dec_off;
    logic [OFF_W:0]   dec_span;

    always_comb begin
        case (load_store_type_e'(req_type))
            L_W, S_W:       dec_size = 3'd4;
            L_H, L_HU, S_H: dec_size = 3'd2;
            L_B, L_BU, S_B: dec_size = 3'd1;
            default:        dec_size = 3'd0;
        endcase
        dec_store  = req_type inside {S_W, S_H, S_B};
        dec_signed = req_type inside {L_W, L_H, L_B};
        dec_off    = req_addr[OFF_W-1:0];
        dec_span   = (OFF_W+1)'(dec_off) + (OFF_W+1)'(dec_size);
        dec_cross  = dec_span > (OFF_W+1)'(BYTES);
        dec_err    = (dec_size == 3'd0) || (dec_cross && !MISALIGNED_SPLIT);
    end

    logic [2:0]        cap_size;
    logic              cap_store, cap_signed, cap_cross, cap_err;
    logic [OFF_W-1:0]  cap_off;
    logic [ADDR_W-1:0] cap_base;
    logic [XLEN-1:0]   cap_wdata, rd_lo, rd_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cap_size   <= '0;
            cap_store  <= 1'b0;
            cap_signed <= 1'b0;
            cap_cross  <= 1'b0;
            cap_err    <= 1'b0;
            cap_off    <= '0;
            cap_base   <= '0;
            cap_wdata  <= '0;
            rd_lo      <= '0;
            rd_hi      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                cap_size   <= dec_size;
                cap_store  <= dec_store;
                cap_signed <= dec_signed;
                cap_cross  <= dec_cross;
                cap_err    <= dec_err;
                cap_off    <= dec_off;
                cap_base   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                cap_wdata  <= req_wdata;
            end
            if (state_q == WAIT0 && mem_rvalid) rd_lo <= mem_rdata;
            if (state_q == WAIT1 && mem_rvalid) rd_hi <= mem_rdata;
        end
    end

    // Two-beat window: low half belongs to beat0, high half to beat1
    logic [2*BYTES-1:0] byte_mask;
    logic [2*XLEN-1:0]  wide_wdata, wide_rdata;
    logic [XLEN-1:0]    raw, load_data;
    logic               sign_bit;

    always_comb begin
        for (int i = 0; i < 2*BYTES; i++)
            byte_mask[i] = (i >= int'(cap_off)) && (i < int'(cap_off) + int'(cap_size));
        wide_wdata = {{XLEN{1'b0}}, cap_wdata} << {cap_off, 3'b000};
        wide_rdata = {rd_hi, rd_lo} >> {cap_off, 3'b000};
        raw        = wide_rdata[XLEN-1:0];
        case (cap_size)
            3'd1:    sign_bit = raw[7];
            3'd2:    sign_bit = raw[15];
            default: sign_bit = raw[31];
        endcase
        sign_bit  = sign_bit & cap_signed;
        load_data = raw;
        for (int i = 8; i < XLEN; i++)
            if (i >= 8*int'(cap_size)) load_data[i] = sign_bit;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = dec_err ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_valid = 1'b1;
                mem_we    = cap_store;
                mem_addr  = cap_base;
                mem_wstrb = byte_mask[BYTES-1:0];
                mem_wdata = wide_wdata[XLEN-1:0];
                if (mem_ready) state_d = !cap_store ? WAIT0 : (cap_cross ? BEAT1 : RESP);
            end
            WAIT0: if (mem_rvalid) state_d = cap_cross ? BEAT1 : RESP;
            BEAT1: begin
                mem_valid = 1'b1;
                mem_we    = cap_store;
                mem_addr  = cap_base + ADDR_W'(BYTES);
                mem_wstrb = byte_mask[2*BYTES-1:BYTES];
                mem_wdata = wide_wdata[2*XLEN-1:XLEN];
                if (mem_ready) state_d = cap_store ? RESP : WAIT1;
            end
            WAIT1: if (mem_rvalid) state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = cap_err;
                if (!cap_err && !cap_store) rsp_rdata = load_data;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Bench for lsu_bus_adapter: byte-level memory model, random bus stalls, directed scenarios.
module tb_lsu_bus_adapter;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_err;
    logic [3:0]  req_type;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        r2_valid, ready2, rsp_valid2, err2, mem_valid2, we2;
    logic [3:0]  r2_type, strb2;
    logic [31:0] r2_addr, r2_wdata, rdata2, addr2, wdata2;
    logic        mem_ready2 = 1'b1, mem_rvalid2 = 1'b0;
    logic [31:0] mem_rdata2 = 32'h0;

    // Bus side: automatic responder or manual control from a test task
    logic        auto_mode, a_ready, a_rvalid, man_ready, man_rvalid;
    logic [31:0] a_rdata, man_rdata;
    int          stall_max, rdly_max;
    assign mem_ready  = auto_mode ? a_ready  : man_ready;
    assign mem_rvalid = auto_mode ? a_rvalid : man_rvalid;
    assign mem_rdata  = auto_mode ? a_rdata  : man_rdata;

    int checks = 0, failures = 0;

    logic [7:0] bus_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    beat_t      obs_q[$];
    beat_t      exp_beats[$];
    logic       exp_err, got_err, got_to, got_again, got_rdy;
    logic [31:0] exp_data, got_data;
    int         exp_lat, got_lat;

    lsu_bus_adapter #(.XLEN(32), .ADDR_W(32), .MISALIGNED_SPLIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    lsu_bus_adapter #(.XLEN(32), .ADDR_W(32), .MISALIGNED_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(ready2),
        .req_type(r2_type), .req_addr(r2_addr), .req_wdata(r2_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rdata2), .rsp_err(err2),
        .mem_valid(mem_valid2), .mem_ready(mem_ready2), .mem_we(we2), .mem_addr(addr2),
        .mem_wstrb(strb2), .mem_wdata(wdata2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2));

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Responder: random stall before ready, random delay before read data
    initial begin
        int          stall_left, rd_cnt;
        logic        rd_pend;
        logic [31:0] rd_data;
        beat_t       b;
        a_ready = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
        stall_left = -1; rd_pend = 1'b0; rd_cnt = 0; rd_data = '0;
        forever begin
            @(negedge clk);
            a_ready = 1'b0; a_rvalid = 1'b0;
            if (!rst_n || !auto_mode) begin
                rd_pend = 1'b0; stall_left = -1;
            end else begin
                if (rd_pend) begin
                    if (rd_cnt == 0) begin a_rvalid = 1'b1; a_rdata = rd_data; rd_pend = 1'b0; end
                    else rd_cnt--;
                end
                if (mem_valid) begin
                    if (stall_left < 0) stall_left = $urandom_range(stall_max, 0);
                    if (stall_left > 0) stall_left--;
                    else begin
                        a_ready = 1'b1; stall_left = -1;
                        b.addr = mem_addr; b.we = mem_we; b.strb = mem_wstrb; b.wdata = mem_wdata;
                        obs_q.push_back(b);
                        if (mem_we) begin
                            for (int j = 0; j < 4; j++)
                                if (mem_wstrb[j]) bus_mem[mem_addr + 32'(j)] = mem_wdata[8*j +: 8];
                        end else begin
                            rd_pend = 1'b1; rd_cnt = $urandom_range(rdly_max, 0);
                            for (int j = 0; j < 4; j++) rd_data[8*j +: 8] = bus_rd(mem_addr + 32'(j));
                        end
                    end
                end
            end
        end
    end

    // Reference: byte-by-byte view of the access against the reference memory
    task automatic model_req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
        int sz, o, nb, k;
        logic st, sgn;
        beat_t b;
        exp_beats.delete();
        case (t)
            4'd0, 4'd5:       sz = 4;
            4'd1, 4'd2, 4'd6: sz = 2;
            4'd3, 4'd4, 4'd7: sz = 1;
            default:          sz = 0;
        endcase
        st  = (t >= 4'd5) && (t <= 4'd7);
        sgn = (t == 4'd0) || (t == 4'd1) || (t == 4'd3);
        o   = int'(a % 4);
        exp_err  = (sz == 0);
        exp_data = '0;
        exp_lat  = 1;
        if (!exp_err) begin
            nb = (o + sz > 4) ? 2 : 1;
            for (int bi = 0; bi < nb; bi++) begin
                b.addr = (a & ~32'h3) + 32'(4*bi);
                b.we = st; b.strb = '0; b.wdata = '0;
                for (int j = 0; j < 4; j++) begin
                    k = 4*bi + j - o;
                    if (k >= 0 && k < sz) b.strb[j] = 1'b1;
                    if (k >= 0 && k < 4) b.wdata[8*j +: 8] = d[8*k +: 8];
                end
                exp_beats.push_back(b);
            end
            if (st) begin
                for (int i = 0; i < sz; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) exp_data[8*i +: 8] = ref_rd(a + 32'(i));
                if (sgn && exp_data[8*sz-1])
                    for (int i = 8*sz; i < 32; i++) exp_data[i] = 1'b1;
            end
            exp_lat = nb * (st ? 1 : 2) + 1;
        end
    endtask

    // Drives one request from a negedge and collects the response; no checking here
    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
        int n;
        obs_q.delete();
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_type = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        got_lat = 1;
        while (!rsp_valid && got_lat < 300) begin @(negedge clk); got_lat++; end
        got_to = !rsp_valid; got_err = rsp_err; got_data = rsp_rdata;
        @(negedge clk);
        got_again = rsp_valid; got_rdy = req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_type = '0; req_addr = '0; req_wdata = '0;
        r2_valid = 1'b0; r2_type = '0; r2_addr = '0; r2_wdata = '0;
        auto_mode = 1'b0; man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        stall_max = 0; rdly_max = 0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({rsp_valid, rsp_err, mem_valid, mem_we, mem_wstrb} !== 8'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 00", {rsp_valid, rsp_err, mem_valid, mem_we, mem_wstrb}); end
        checks++; if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin failures++; $display("FAIL reset_data: got %h want 0", {rsp_rdata, mem_addr, mem_wdata}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || ready2 !== 1'b1 || mem_valid !== 1'b0) begin failures++; $display("FAIL reset_release: got rdy=%b rdy2=%b mv=%b want 1 1 0", req_ready, ready2, mem_valid); end
    endtask

    task automatic test_aligned_load();
        auto_mode = 1'b1; stall_max = 0; rdly_max = 0;
        poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
        model_req(4'd0, 32'h100, 32'h0);
        issue(4'd0, 32'h100, $urandom);
        checks++; if (got_to !== 1'b0 || got_lat != 3) begin failures++; $display("FAIL aligned_latency: got %0d want 3", got_lat); end
        checks++; if (got_err !== 1'b0 || got_data !== 32'hDEADBEEF) begin failures++; $display("FAIL aligned_data: got err=%b %h want 0 deadbeef", got_err, got_data); end
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL aligned_beats: got %0d want 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].addr !== 32'h100 || obs_q[0].strb !== 4'b1111 || obs_q[0].we !== 1'b0) begin failures++; $display("FAIL aligned_beat: got %h %b %b want 100 1111 0", obs_q[0].addr, obs_q[0].strb, obs_q[0].we); end
        end
        checks++; if (got_again !== 1'b0 || got_rdy !== 1'b1) begin failures++; $display("FAIL aligned_pulse: got again=%b rdy=%b want 0 1", got_again, got_rdy); end
    endtask

    task automatic test_byte_ext();
        poke(32'h100, 8'h33); poke(32'h101, 8'h22); poke(32'h102, 8'h11); poke(32'h103, 8'h80);
        issue(4'd3, 32'h103, $urandom);
        checks++; if (got_to !== 1'b0 || got_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sext: got %h want ffffff80", got_data); end
        checks++; if (obs_q.size() != 1 || obs_q[0].strb !== 4'b1000 || obs_q[0].addr !== 32'h100) begin failures++; $display("FAIL lb_beat: got n=%0d want one beat at 100 strb 1000", obs_q.size()); end
        issue(4'd4, 32'h103, $urandom);
        checks++; if (got_to !== 1'b0 || got_data !== 32'h00000080) begin failures++; $display("FAIL lbu_zext: got %h want 00000080", got_data); end
    endtask

    task automatic test_store_stall();
        logic ok;
        auto_mode = 1'b0; man_ready = 1'b0;
        req_valid = 1'b1; req_type = 4'd6; req_addr = 32'h102; req_wdata = 32'h0000ABCD;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        for (int i = 0; i < 4; i++) begin
            ok = mem_valid === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h100 && mem_wstrb === 4'b1100 && mem_wdata === 32'hABCD0000;
            checks++; if (!ok) begin failures++; $display("FAIL stall_hold%0d: got v=%b we=%b a=%h s=%b d=%h want 1 1 100 1100 abcd0000", i, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata); end
            man_ready = (i == 3);
            @(negedge clk);
        end
        man_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL stall_rsp: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL stall_after: got v=%b rdy=%b want 0 1", rsp_valid, req_ready); end
        poke(32'h102, 8'hCD); poke(32'h103, 8'hAB);
    endtask

    task automatic test_split();
        auto_mode = 1'b1; stall_max = 0; rdly_max = 0;
        for (int i = 0; i < 8; i++) poke(32'hFC + 32'(i), 8'(8'h11 * (i + 1)));
        issue(4'd0, 32'hFE, $urandom);
        checks++; if (got_to !== 1'b0 || got_lat != 5) begin failures++; $display("FAIL split_latency: got %0d want 5", got_lat); end
        checks++; if (got_data !== 32'h66554433 || got_err !== 1'b0) begin failures++; $display("FAIL split_load: got %h want 66554433", got_data); end
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL split_nbeats: got %0d want 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].addr !== 32'hFC || obs_q[0].strb !== 4'b1100 || obs_q[1].addr !== 32'h100 || obs_q[1].strb !== 4'b0011) begin failures++; $display("FAIL split_load_beats: got %h/%b %h/%b want fc/1100 100/0011", obs_q[0].addr, obs_q[0].strb, obs_q[1].addr, obs_q[1].strb); end
        end
        model_req(4'd5, 32'hFF, 32'hAABBCCDD);
        issue(4'd5, 32'hFF, 32'hAABBCCDD);
        checks++; if (got_to !== 1'b0 || got_err !== 1'b0 || got_data !== 32'h0) begin failures++; $display("FAIL split_store_rsp: got e=%b d=%h want 0 0", got_err, got_data); end
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL split_store_nbeats: got %0d want 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].strb !== 4'b1000 || obs_q[0].wdata !== 32'hDD000000 || obs_q[0].we !== 1'b1) begin failures++; $display("FAIL split_store_b0: got %b %h want 1000 dd000000", obs_q[0].strb, obs_q[0].wdata); end
            checks++; if (obs_q[1].strb !== 4'b0111 || obs_q[1].wdata !== 32'h00AABBCC || obs_q[1].addr !== 32'h100) begin failures++; $display("FAIL split_store_b1: got %b %h want 0111 00aabbcc", obs_q[1].strb, obs_q[1].wdata); end
        end
    endtask

    task automatic test_errors();
        logic [3:0]  tt [5];
        logic [31:0] aa [5];
        logic        saw;
        tt = '{4'd1, 4'd8, 4'd15, 4'd0, 4'd7};
        aa = '{32'h103, 32'h100, 32'h200, 32'h101, 32'h103};
        for (int i = 0; i < 5; i++) begin
            r2_valid = 1'b1; r2_type = tt[i]; r2_addr = aa[i]; r2_wdata = $urandom;
            @(negedge clk);
            r2_valid = 1'b0; saw = mem_valid2;
            if (i < 4) begin
                checks++; if (rsp_valid2 !== 1'b1 || err2 !== 1'b1 || rdata2 !== 32'h0 || saw !== 1'b0) begin failures++; $display("FAIL err_ns%0d: got v=%b e=%b d=%h mv=%b want 1 1 0 0", i, rsp_valid2, err2, rdata2, saw); end
            end else begin
                checks++; if (saw !== 1'b1 || strb2 !== 4'b1000 || we2 !== 1'b1) begin failures++; $display("FAIL ns_store_beat: got mv=%b s=%b we=%b want 1 1000 1", saw, strb2, we2); end
                @(negedge clk);
                checks++; if (rsp_valid2 !== 1'b1 || err2 !== 1'b0) begin failures++; $display("FAIL ns_store_rsp: got v=%b e=%b want 1 0", rsp_valid2, err2); end
            end
            @(negedge clk);
            checks++; if (rsp_valid2 !== 1'b0 || ready2 !== 1'b1) begin failures++; $display("FAIL err_ns_after%0d: got v=%b rdy=%b want 0 1", i, rsp_valid2, ready2); end
        end
        issue(4'd8, 32'h100, $urandom);
        checks++; if (got_lat != 1 || got_err !== 1'b1 || got_data !== 32'h0 || obs_q.size() != 0) begin failures++; $display("FAIL err_lsna: got lat=%0d e=%b d=%h beats=%0d want 1 1 0 0", got_lat, got_err, got_data, obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        auto_mode = 1'b0; man_ready = 1'b0; man_rvalid = 1'b0;
        req_valid = 1'b1; req_type = 4'd0; req_addr = 32'hFE;
        @(negedge clk);
        req_valid = 1'b0; man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h44332211;
        @(negedge clk);
        man_rvalid = 1'b0;
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wstrb !== 4'b0011) begin failures++; $display("FAIL mid_beat1: got v=%b a=%h s=%b want 1 100 0011", mem_valid, mem_addr, mem_wstrb); end
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || {rsp_valid, rsp_err, mem_valid, mem_we, mem_wstrb} !== 8'h0 || {rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin failures++; $display("FAIL mid_async: got rdy=%b v=%b mv=%b a=%h want 1 0 0 0", req_ready, rsp_valid, mem_valid, mem_addr); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b1; man_rdata = 32'h88776655;
        @(negedge clk);
        man_rvalid = 1'b0; seen = 1'b0;
        for (int i = 0; i < 4; i++) begin seen |= rsp_valid | mem_valid; @(negedge clk); end
        checks++; if (seen !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_stray: got activity=%b rdy=%b want 0 1", seen, req_ready); end
        auto_mode = 1'b1; stall_max = 0; rdly_max = 0;
        model_req(4'd0, 32'h100, 32'h0);
        issue(4'd0, 32'h100, $urandom);
        checks++; if (got_to !== 1'b0 || got_lat != 3 || got_data !== exp_data || got_err !== 1'b0) begin failures++; $display("FAIL mid_next: got lat=%0d d=%h want 3 %h", got_lat, got_data, exp_data); end
    endtask

    task automatic test_random();
        auto_mode = 1'b1;
        for (int it = 0; it < 80; it++) begin
            logic [3:0]  t;
            logic [31:0] a, d;
            t = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(7, 0));
            a = 32'h200 + 32'($urandom_range(23, 0));
            d = $urandom;
            stall_max = $urandom_range(2, 0); rdly_max = $urandom_range(2, 0);
            model_req(t, a, d);
            issue(t, a, d);
            checks++; if (got_to !== 1'b0) begin failures++; $display("FAIL rnd%0d_timeout: got no response want response", it); end
            checks++; if (got_err !== exp_err || got_data !== exp_data) begin failures++; $display("FAIL rnd%0d_rsp: t=%0d a=%h got e=%b d=%h want e=%b d=%h", it, t, a, got_err, got_data, exp_err, exp_data); end
            checks++; if (got_again !== 1'b0 || got_rdy !== 1'b1) begin failures++; $display("FAIL rnd%0d_pulse: got again=%b rdy=%b want 0 1", it, got_again, got_rdy); end
            if (stall_max == 0 && rdly_max == 0) begin
                checks++; if (got_lat != exp_lat) begin failures++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, got_lat, exp_lat); end
            end
            checks++; if (obs_q.size() != exp_beats.size()) begin failures++; $display("FAIL rnd%0d_nbeats: got %0d want %0d", it, obs_q.size(), exp_beats.size()); end
            else begin
                foreach (exp_beats[i]) begin
                    checks++; if (obs_q[i].addr !== exp_beats[i].addr || obs_q[i].we !== exp_beats[i].we || obs_q[i].strb !== exp_beats[i].strb || (exp_beats[i].we && obs_q[i].wdata !== exp_beats[i].wdata)) begin failures++; $display("FAIL rnd%0d_beat%0d: got %h %b %b %h want %h %b %b %h", it, i, obs_q[i].addr, obs_q[i].we, obs_q[i].strb, obs_q[i].wdata, exp_beats[i].addr, exp_beats[i].we, exp_beats[i].strb, exp_beats[i].wdata); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_byte_ext();
        test_store_stall();
        test_split();
        test_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
